// File: rtl/sprite_blit.sv
// -----------------------------------------------------------------------------
// sprite_blit
//
// Copies a W x H one-bit sprite bitmap into a 640x480 framebuffer. The pixels
// go out one per cycle in row-major order over a valid/ready write port.
// Pixels that land outside the visible area are clipped (skipped without a
// write). A skipped pixel still takes one cycle so the scan keeps moving.
//
// Parameters
//   W         sprite width in pixels
//   H         sprite height in pixels
//
// Ports
//   clk        single clock
//   reset      synchronous, active-high reset
//   start      request to blit one sprite (sampled only while idle)
//   x, y       sprite top-left corner (column, row)
//   data       sprite bitmap, data[r][c] is the pixel at (x+c, y+r)
//   busy       high while pixels are being scanned
//   done       one-cycle pulse after the last pixel
//   fb_x/fb_y  framebuffer write address
//   fb_color   framebuffer write value
//   fb_we      framebuffer write request
//   fb_ready   framebuffer accepts the write this cycle
//
// Build option
//   SPRITE_BLIT_TRANSPARENT_EN  when defined, 0-pixels are treated as
//                               transparent and skipped instead of written.
// -----------------------------------------------------------------------------
module sprite_blit #(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [9:0]   x,
  input  logic [8:0]   y,
  input  logic [W-1:0] data [H],
  output logic         busy,
  output logic         done,
  output logic [9:0]   fb_x,
  output logic [8:0]   fb_y,
  output logic         fb_color,
  output logic         fb_we,
  input  logic         fb_ready
);

  // Counter widths. There is always at least one bit, so W=1 or H=1 still
  // gives legal vectors.
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  // Visible framebuffer bounds used for clipping.
  localparam logic [10:0] FB_WIDTH  = 11'd640;
  localparam logic [9:0]  FB_HEIGHT = 10'd480;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [9:0]     x_q;
  logic [8:0]     y_q;
  logic [W-1:0]   data_q [H];

  // Captures the sprite position and bitmap. The blit in progress then does
  // not see later changes on the inputs.
  logic           latch_en;

  // ---------------------------------------------------------------------------
  // Current pixel
  // ---------------------------------------------------------------------------
  logic [10:0]    px;
  logic [9:0]     py;
  logic           pix_bit;
  logic           clipped;
  logic           skip;
  logic           in_write;
  logic           wr_req;
  logic           advance;
  logic           last_pix;

  // The sums are one bit wider than the framebuffer coordinates. A sprite
  // that hangs past column 1023 or row 511 must clip, not wrap back to 0.
  assign px       = {1'b0, x_q} + 11'(col_q);
  assign py       = {1'b0, y_q} + 10'(row_q);
  assign pix_bit  = data_q[row_q][col_q];
  assign clipped  = (px >= FB_WIDTH) || (py >= FB_HEIGHT);

`ifdef SPRITE_BLIT_TRANSPARENT_EN
  assign skip     = clipped || !pix_bit;
`else
  assign skip     = clipped;
`endif

  assign in_write = (state_q == S_WRITE);
  assign wr_req   = in_write && !skip;
  // A skipped pixel advances on its own. A written pixel waits for the
  // handshake, and the address stays on the port while it waits.
  assign advance  = in_write && (skip || fb_ready);
  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // ---------------------------------------------------------------------------
  // Write port. These outputs depend only on registered state.
  // They are forced to zero whenever no write is requested, so idle and reset
  // both show an all-zero port.
  // ---------------------------------------------------------------------------
  assign fb_we    = wr_req;
  assign fb_x     = wr_req ? px[9:0] : 10'd0;
  assign fb_y     = wr_req ? py[8:0] : 9'd0;
  assign fb_color = wr_req ? pix_bit : 1'b0;

  assign busy     = busy_q;
  assign done     = done_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    latch_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          latch_en = 1'b1;
          col_d    = '0;
          row_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_WRITE;
        end
      end

      S_WRITE: begin
        // start is deliberately not looked at here.
        if (advance) begin
          if (last_pix) begin
            col_d   = '0;
            row_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      S_DONE: begin
        // done is high for this single cycle only. start is ignored here too.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM, counters, registered status outputs and latched position
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (latch_en) begin
        x_q <= x;
        y_q <= y;
      end
    end
  end

  // Bitmap capture, one register row per sprite row.
  generate
    for (genvar gi = 0; gi < H; gi++) begin : g_row
      always_ff @(posedge clk) begin
        if (reset) begin
          data_q[gi] <= '0;
        end else if (latch_en) begin
          data_q[gi] <= data[gi];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sprite_blit.sv
// -----------------------------------------------------------------------------
// tb_sprite_blit
//
// Self-checking bench for sprite_blit with W=4, H=4.
// - A directed table covers the listed scenarios.
// - Hand-written sequences cover reset mid-blit.
// - A randomized loop covers position, bitmap, backpressure and spurious
//   start pulses.
// Expected values come from a pixel-list reference model. The model walks
// the sprite in row-major order, applies the clipping and transparency rules,
// and plays the write handshake against the fb_ready schedule the bench
// drives.
// -----------------------------------------------------------------------------
module tb_sprite_blit;

  localparam int W      = 4;
  localparam int H      = 4;
  localparam int BUDGET = 200;

`ifdef SPRITE_BLIT_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [9:0]   x;
  logic [8:0]   y;
  logic [W-1:0] data [H];
  logic         busy;
  logic         done;
  logic [9:0]   fb_x;
  logic [8:0]   fb_y;
  logic         fb_color;
  logic         fb_we;
  logic         fb_ready;

  always #5 clk = ~clk;

  sprite_blit #(.W(W), .H(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x        (x),
    .y        (y),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .fb_x     (fb_x),
    .fb_y     (fb_y),
    .fb_color (fb_color),
    .fb_we    (fb_we),
    .fb_ready (fb_ready)
  );

  typedef struct packed {
    logic [9:0] px;
    logic [8:0] py;
    logic       c;
  } pres_t;

  typedef struct {
    int bx;
    int by;
    int mode;       // 0: always ready, 1: not ready in cycles 2..4
    int restart_t;  // cycle at which a stray start is pulsed (0: none)
    int exp_ntx;    // expected number of transfers
    int exp_tdone;  // expected cycle of done (cycle 1 = first pixel cycle)
    int exp_hold;   // expected cycles presenting (5,4)
  } vec_t;

  pres_t        obs_q[$];
  pres_t        exp_q[$];
  bit           rdy [BUDGET+1];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] diag [H];
  vec_t         vt [8];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model. It builds the list of sprite pixels in scan order and
  // marks the ones that are not written. It then steps through cycles: a
  // skipped pixel uses one cycle, and a written pixel is shown every cycle
  // until fb_ready is high.
  task automatic model(input int bx, input int by, input logic [W-1:0] d [H],
                       output int tdone, output int ntx);
    int    t;
    int    i;
    int    px_l [W*H];
    int    py_l [W*H];
    bit    c_l  [W*H];
    bit    sk_l [W*H];
    pres_t p;
    exp_q.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        px_l[r*W+c] = bx + c;
        py_l[r*W+c] = by + r;
        c_l[r*W+c]  = d[r][c];
        sk_l[r*W+c] = (bx + c >= 640) || (by + r >= 480) || (TRANSP && !d[r][c]);
      end
    end
    t   = 1;
    i   = 0;
    ntx = 0;
    while (i < W*H && t < BUDGET) begin
      if (sk_l[i]) begin
        i++;
      end else begin
        p.px = 10'(px_l[i]);
        p.py = 9'(py_l[i]);
        p.c  = c_l[i];
        exp_q.push_back(p);
        if (rdy[t]) begin
          i++;
          ntx++;
        end
      end
      t++;
    end
    tdone = t;
  endtask

  // Runs one blit starting at posedge+1 in idle and compares it to the model.
  // It returns at posedge+1 two cycles after done.
  task automatic run_blit(input string tag, input int bx, input int by,
                          input logic [W-1:0] d [H], input int mode,
                          input int restart_t);
    int exp_tdone;
    int exp_ntx;
    int tdone_obs;
    int ntx_obs;
    int busy_err;
    int extra_done;
    int n;
    pres_t p;
    for (int t = 0; t <= BUDGET; t++) begin
      case (mode)
        0:       rdy[t] = 1'b1;
        1:       rdy[t] = !(t >= 2 && t <= 4);
        default: rdy[t] = ($urandom_range(0, 3) != 0);
      endcase
    end
    model(bx, by, d, exp_tdone, exp_ntx);
    obs_q.delete();
    start = 1'b1;
    x     = 10'(bx);
    y     = 9'(by);
    for (int r = 0; r < H; r++) data[r] = d[r];
    @(posedge clk); #1;
    // Scramble the inputs right after they are latched.
    start = 1'b0;
    x     = 10'($urandom);
    y     = 9'($urandom);
    for (int r = 0; r < H; r++) data[r] = W'($urandom);
    tdone_obs = -1;
    ntx_obs   = 0;
    busy_err  = 0;
    for (int t = 1; t < BUDGET; t++) begin
      fb_ready = rdy[t];
      start    = (t == restart_t);
      if (t == restart_t) begin
        x = 10'($urandom);
        y = 9'($urandom);
      end
      @(negedge clk);
      if (fb_we) begin
        p.px = fb_x;
        p.py = fb_y;
        p.c  = fb_color;
        obs_q.push_back(p);
        if (fb_ready) ntx_obs++;
      end
      if (done) begin
        tdone_obs = t;
        if (busy || fb_we) busy_err++;
      end else if (!busy) begin
        busy_err++;
      end
      @(posedge clk); #1;
      if (tdone_obs >= 0) break;
    end
    start    = 1'b0;
    fb_ready = 1'b1;
    check({tag, "_done_cycle"}, tdone_obs, exp_tdone);
    check({tag, "_transfers"}, ntx_obs, exp_ntx);
    check({tag, "_busy_profile_errs"}, busy_err, 0);
    check({tag, "_presented"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_pix%0d", tag, i), int'(obs_q[i]), int'(exp_q[i]));
    // The cycle after done must be idle, and no second done may follow.
    extra_done = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (done || busy || fb_we) extra_done++;
      @(posedge clk); #1;
    end
    check({tag, "_idle_after_done"}, extra_done, 0);
    $display("blit %s x=%0d y=%0d mode=%0d writes=%0d done_cycle=%0d",
             tag, bx, by, mode, ntx_obs, tdone_obs);
  endtask

  initial begin
    logic [W-1:0] rnd [H];
    int hold;
    int stray;

    for (int i = 0; i < H; i++) diag[i] = W'(1 << i);

    //       bx   by   mode rs  ntx                tdone             hold
    vt[0] = '{4,   4,   0,  0, TRANSP ? 4 : 16,  17,               TRANSP ? 0 : 1};
    vt[1] = '{4,   4,   1,  0, TRANSP ? 4 : 16,  TRANSP ? 17 : 20, TRANSP ? 0 : 4};
    vt[2] = '{638, 478, 0,  0, TRANSP ? 2 : 4,   17,               0};
    vt[3] = '{0,   0,   0,  0, TRANSP ? 4 : 16,  17,               0};
    vt[4] = '{640, 0,   0,  0, 0,                17,               0};
    vt[5] = '{636, 0,   0,  0, TRANSP ? 4 : 16,  17,               0};
    vt[6] = '{0,   479, 0,  0, TRANSP ? 1 : 4,   17,               0};
    vt[7] = '{4,   4,   0,  3, TRANSP ? 4 : 16,  17,               TRANSP ? 0 : 1};

    // Reset state
    reset    = 1'b1;
    start    = 1'b0;
    fb_ready = 1'b1;
    x        = '0;
    y        = '0;
    for (int r = 0; r < H; r++) data[r] = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_x", fb_x, 0);
    check("rst_fb_y", fb_y, 0);
    check("rst_fb_color", fb_color, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table. The model compares each blit pixel by pixel; the table
    // holds hand-computed totals.
    for (int v = 0; v < 8; v++) begin
      run_blit($sformatf("vec%0d", v), vt[v].bx, vt[v].by, diag, vt[v].mode,
               vt[v].restart_t);
      hold = 0;
      foreach (obs_q[i]) if (obs_q[i].px == 10'd5 && obs_q[i].py == 9'd4) hold++;
      check($sformatf("vec%0d_tbl_transfers", v), obs_q.size() - (vt[v].exp_tdone - 17),
            vt[v].exp_ntx);
      check($sformatf("vec%0d_tbl_hold54", v), hold, vt[v].exp_hold);
    end

    // Reset during the 6th write cycle, then a fresh blit.
    for (int t = 0; t <= BUDGET; t++) rdy[t] = 1'b1;
    start = 1'b1;
    x     = 10'd4;
    y     = 9'd4;
    for (int r = 0; r < H; r++) data[r] = diag[r];
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_6th_we", fb_we, 1);
    check("midrst_6th_x", fb_x, 5);
    check("midrst_6th_y", fb_y, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_fb_we", fb_we, 0);
    check("midrst_fb_x", fb_x, 0);
    check("midrst_fb_y", fb_y, 0);
    check("midrst_fb_color", fb_color, 0);
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || busy) stray++;
      @(negedge clk);
    end
    check("midrst_no_done", stray, 0);
    @(posedge clk); #1;
    run_blit("after_rst", 10, 20, diag, 0, 0);

    // Randomized blits with random backpressure and stray start pulses.
    for (int it = 0; it < 25; it++) begin
      for (int r = 0; r < H; r++) rnd[r] = W'($urandom);
      run_blit($sformatf("rnd%0d", it), int'($urandom_range(0, 660)),
               int'($urandom_range(0, 500)), rnd, 2,
               int'($urandom_range(0, 10)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
